// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and configuration helpers for the segmented pipelined adder.
package adder_pkg;

    localparam int DEF_WIDTH = 256;
    localparam int DEF_SEG_W = 64;

    function automatic int calc_nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    function automatic bit cfg_ok(input int width, input int seg_w);
        return seg_w >= 1 && seg_w <= width && (width % seg_w) == 0;
    endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// adder_seg_stage: one SEG_W-bit registered add with carry-in/carry-out, enable and sync reset.
module adder_seg_stage #(
    parameter int SEG_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             ci_i,
    output logic [SEG_W-1:0] s_o,
    output logic             co_o
);

    logic [SEG_W:0] r_q, r_d;

    assign r_d = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, ci_i};

    always_ff @(posedge clk) begin
        if (rst)
            r_q <= '0;
        else if (en_i)
            r_q <= r_d;
    end

    assign s_o  = r_q[SEG_W-1:0];
    assign co_o = r_q[SEG_W];

endmodule

// File: rtl/adder_pipe_seg.sv
// adder_pipe_seg: WIDTH-bit add split into NSEG registered segments with valid/ready backpressure.
// Optional ADDER_PIPE_SEG_OVF_EN adds lane_cout, the raw per-segment carries aligned with sum.
module adder_pipe_seg
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     cin,
    input  logic                     C_EN,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         sum,
`ifdef ADDER_PIPE_SEG_OVF_EN
    output logic [WIDTH/SEG_W-1:0]   lane_cout,
`endif
    output logic                     cout
);

    localparam int NSEG = calc_nseg(WIDTH, SEG_W);
    localparam int MW   = NSEG > 1 ? NSEG - 1 : 1;

    if (!cfg_ok(WIDTH, SEG_W)) begin : g_cfg_err
        $error("adder_pipe_seg: WIDTH must be a positive multiple of SEG_W");
    end

    logic             advance;
    logic [NSEG-1:0]  v_q;
    logic [MW-1:0]    m_q;
    logic [NSEG-1:0]  co;
    logic [SEG_W-1:0] s [NSEG];

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[NSEG-1];
    assign cout      = co[NSEG-1];

    // m_q[k] is the C_EN captured with the beat currently held in stage k
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            m_q <= '0;
        end else if (advance) begin
            v_q <= NSEG'({v_q, in_valid});
            m_q <= MW'({m_q, C_EN});
        end
    end

    for (genvar j = 0; j < NSEG; j++) begin : g_seg
        logic [SEG_W-1:0] a_op, b_op;
        logic             ci, en;

        if (j == 0) begin : g_in
            assign a_op = a[SEG_W-1:0];
            assign b_op = b[SEG_W-1:0];
            assign ci   = cin & C_EN;
            assign en   = advance & in_valid;
        end else begin : g_skew
            logic [SEG_W-1:0] a_q [j];
            logic [SEG_W-1:0] b_q [j];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < j; i++) begin
                        a_q[i] <= '0;
                        b_q[i] <= '0;
                    end
                end else if (advance) begin
                    a_q[0] <= a[j*SEG_W +: SEG_W];
                    b_q[0] <= b[j*SEG_W +: SEG_W];
                    for (int i = 1; i < j; i++) begin
                        a_q[i] <= a_q[i-1];
                        b_q[i] <= b_q[i-1];
                    end
                end
            end
            assign a_op = a_q[j-1];
            assign b_op = b_q[j-1];
            assign ci   = co[j-1] & m_q[j-1];
            assign en   = advance & v_q[j-1];
        end

        adder_seg_stage #(.SEG_W(SEG_W)) u_stage (
            .clk  (clk),
            .rst  (rst),
            .en_i (en),
            .a_i  (a_op),
            .b_i  (b_op),
            .ci_i (ci),
            .s_o  (s[j]),
            .co_o (co[j])
        );

        if (j == NSEG - 1) begin : g_top
            assign sum[j*SEG_W +: SEG_W] = s[j];
`ifdef ADDER_PIPE_SEG_OVF_EN
            assign lane_cout[j] = co[j];
`endif
        end else begin : g_deskew
            localparam int D = NSEG - 1 - j;
            logic [SEG_W-1:0] d_q [D];
            // each deskew slot only moves when a valid beat passes, so sum holds over bubbles
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < D; i++)
                        d_q[i] <= '0;
                end else if (advance) begin
                    if (v_q[j])
                        d_q[0] <= s[j];
                    for (int i = 1; i < D; i++)
                        if (v_q[j+i])
                            d_q[i] <= d_q[i-1];
                end
            end
            assign sum[j*SEG_W +: SEG_W] = d_q[D-1];
`ifdef ADDER_PIPE_SEG_OVF_EN
            logic [D-1:0] lc_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    lc_q <= '0;
                end else if (advance) begin
                    if (v_q[j])
                        lc_q[0] <= co[j];
                    for (int i = 1; i < D; i++)
                        if (v_q[j+i])
                            lc_q[i] <= lc_q[i-1];
                end
            end
            assign lane_cout[j] = lc_q[D-1];
`endif
        end
    end

endmodule

// File: tb/tb_adder_pipe_seg.sv
// tb_adder_pipe_seg: directed and randomised checks of adder_pipe_seg at 256/64, 64/64 and 32/8.
module tb_adder_pipe_seg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, cin, c_en, out_ready;
    logic [255:0] a, b, sum;
    logic         in_ready, out_valid, cout;

    logic         s64_in_valid, s64_cin, s64_c_en, s64_in_ready, s64_out_valid, s64_cout;
    logic [63:0]  s64_a, s64_b, s64_sum;
    logic         s32_in_valid, s32_cin, s32_c_en, s32_in_ready, s32_out_valid, s32_cout;
    logic [31:0]  s32_a, s32_b, s32_sum;
`ifdef ADDER_PIPE_SEG_OVF_EN
    logic [3:0]   lane_cout;
    logic [0:0]   s64_lane_cout;
    logic [3:0]   s32_lane_cout;
`endif

    int tests = 0;
    int fails = 0;

    logic [256:0] q0[$], q64[$], q32[$];
`ifdef ADDER_PIPE_SEG_OVF_EN
    logic [3:0]   lq[$];
`endif

    adder_pipe_seg #(.WIDTH(256), .SEG_W(64)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .C_EN(c_en), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
`ifdef ADDER_PIPE_SEG_OVF_EN
        .lane_cout(lane_cout),
`endif
        .cout(cout)
    );

    adder_pipe_seg #(.WIDTH(64), .SEG_W(64)) u_d64 (
        .clk(clk), .rst(rst), .in_valid(s64_in_valid), .in_ready(s64_in_ready), .a(s64_a), .b(s64_b),
        .cin(s64_cin), .C_EN(s64_c_en), .out_valid(s64_out_valid), .out_ready(1'b1), .sum(s64_sum),
`ifdef ADDER_PIPE_SEG_OVF_EN
        .lane_cout(s64_lane_cout),
`endif
        .cout(s64_cout)
    );

    adder_pipe_seg #(.WIDTH(32), .SEG_W(8)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(s32_in_valid), .in_ready(s32_in_ready), .a(s32_a), .b(s32_b),
        .cin(s32_cin), .C_EN(s32_c_en), .out_valid(s32_out_valid), .out_ready(1'b1), .sum(s32_sum),
`ifdef ADDER_PIPE_SEG_OVF_EN
        .lane_cout(s32_lane_cout),
`endif
        .cout(s32_cout)
    );

    // reference: bit 256 = cout, low w bits = sum
    function automatic logic [256:0] model(input logic [255:0] x, y, input logic ci, en,
                                           input int w, input int s);
        logic [256:0] r, t, m;
        r = '0;
        m = (257'd1 << s) - 257'd1;
        if (en) begin
            t = {1'b0, x} + {1'b0, y} + {256'd0, ci};
            r = t & ((257'd1 << w) - 257'd1);
            r[256] = t[w];
        end else begin
            for (int l = 0; l < w / s; l++) begin
                t = ((({1'b0, x}) >> (l * s)) & m) + ((({1'b0, y}) >> (l * s)) & m);
                r = r | ((t & m) << (l * s));
                if (l == w / s - 1)
                    r[256] = t[s];
            end
        end
        return r;
    endfunction

`ifdef ADDER_PIPE_SEG_OVF_EN
    function automatic logic [3:0] model_lc(input logic [255:0] x, y, input logic ci, en);
        logic [256:0] t, lm, m;
        logic [3:0]   r;
        m = (257'd1 << 64) - 257'd1;
        for (int j = 0; j < 4; j++) begin
            lm = (257'd1 << ((j + 1) * 64)) - 257'd1;
            if (en)
                t = ({1'b0, x} & lm) + ({1'b0, y} & lm) + {256'd0, ci};
            else
                t = (({1'b0, x} >> (j * 64)) & m) + (({1'b0, y} >> (j * 64)) & m);
            r[j] = en ? t[(j + 1) * 64] : t[64];
        end
        return r;
    endfunction
`endif

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++)
            r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (sum !== 256'd0) begin fails++; $display("FAIL reset_sum: got %h want 0", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL reset_cout: got %b want 0", cout); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef ADDER_PIPE_SEG_OVF_EN
        tests++; if (lane_cout !== 4'b0) begin fails++; $display("FAIL reset_lane_cout: got %b want 0", lane_cout); end
`endif
    endtask

    task automatic test_full_ripple();
        int lat;
        a = '1; b = '0; cin = 1'b1; c_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        tests++; if (lat !== 4) begin fails++; $display("FAIL ripple_latency: got %0d want 4", lat); end
        tests++; if (sum !== 256'd0) begin fails++; $display("FAIL ripple_sum: got %h want 0", sum); end
        tests++; if (cout !== 1'b1) begin fails++; $display("FAIL ripple_cout: got %b want 1", cout); end
`ifdef ADDER_PIPE_SEG_OVF_EN
        tests++; if (lane_cout !== 4'b1111) begin fails++; $display("FAIL ripple_lane_cout: got %b want 1111", lane_cout); end
`endif
        drain();
    endtask

    task automatic test_lane();
        int lat;
        a = '1; b = {4{64'd1}}; cin = 1'b1; c_en = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        tests++; if (lat !== 4) begin fails++; $display("FAIL lane_latency: got %0d want 4", lat); end
        tests++; if (sum !== 256'd0) begin fails++; $display("FAIL lane_sum: got %h want 0", sum); end
        tests++; if (cout !== 1'b1) begin fails++; $display("FAIL lane_cout_top: got %b want 1", cout); end
`ifdef ADDER_PIPE_SEG_OVF_EN
        tests++; if (lane_cout !== 4'b1111) begin fails++; $display("FAIL lane_lane_cout: got %b want 1111", lane_cout); end
`endif
        drain();
        // cross-lane isolation: lane 0 overflows, lane 1 must not see it
        a = {192'd0, 64'hFFFF_FFFF_FFFF_FFFF}; b = {192'd0, 64'd2}; cin = 1'b0; c_en = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        tests++; if (sum !== {192'd0, 64'd1} || cout !== 1'b0) begin
            fails++; $display("FAIL lane_isolation: got %h/%b want %h/0", sum, cout, {192'd0, 64'd1});
        end
`ifdef ADDER_PIPE_SEG_OVF_EN
        tests++; if (lane_cout !== 4'b0001) begin fails++; $display("FAIL lane_iso_lane_cout: got %b want 0001", lane_cout); end
`endif
        drain();
    endtask

    task automatic test_back_to_back();
        int first, last, got;
        logic [256:0] e;
        q0.delete();
`ifdef ADDER_PIPE_SEG_OVF_EN
        lq.delete();
`endif
        first = -1; last = -1; got = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid = cyc < 8;
            a = rand256(); b = rand256(); cin = 1'b1; c_en = (cyc % 2) == 0;
            if (cyc < 5) begin a = '1; b = {4{64'd1}}; end
            #1;
            if (in_valid) begin
                tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
                q0.push_back(model(a, b, cin, c_en, 256, 64));
`ifdef ADDER_PIPE_SEG_OVF_EN
                lq.push_back(model_lc(a, b, cin, c_en));
`endif
            end
            if (out_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                got++;
                e = q0.size() > 0 ? q0.pop_front() : '1;
                tests++; if ({cout, sum} !== e) begin fails++; $display("FAIL b2b_result: got %b/%h want %b/%h", cout, sum, e[256], e[255:0]); end
`ifdef ADDER_PIPE_SEG_OVF_EN
                if (lq.size() > 0) begin
                    tests++; if (lane_cout !== lq[0]) begin fails++; $display("FAIL b2b_lane_cout: got %b want %b", lane_cout, lq[0]); end
                    void'(lq.pop_front());
                end
`endif
            end
            tick();
        end
        tests++; if (got !== 8) begin fails++; $display("FAIL b2b_count: got %0d want 8", got); end
        tests++; if (first !== 4 || last - first !== 7) begin fails++; $display("FAIL b2b_spacing: got first %0d last %0d want 4/11", first, last); end
        drain();
    endtask

    task automatic test_backpressure();
        int sent, got, cyc;
        logic stall_prev, cout_prev;
        logic [255:0] sum_prev;
        logic [256:0] e;
        logic need;
        q0.delete();
        sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; need = 1'b1;
        sum_prev = '0; cout_prev = 1'b0;
        while ((got < 10 || sent < 10) && cyc < 300) begin
            if (stall_prev) begin
                tests++; if (out_valid !== 1'b1 || sum !== sum_prev || cout !== cout_prev) begin
                    fails++; $display("FAIL bp_stall_hold: got %b/%b/%h want 1/%b/%h", out_valid, cout, sum, cout_prev, sum_prev);
                end
            end
            out_ready = $urandom_range(0, 1) == 1;
            in_valid = sent < 10;
            if (need) begin
                a = rand256(); b = rand256(); cin = $urandom_range(0, 1) == 1; c_en = $urandom_range(0, 1) == 1;
                need = 1'b0;
            end
            #1;
            tests++; if (in_ready !== !(out_valid && !out_ready)) begin
                fails++; $display("FAIL bp_in_ready: got %b want %b", in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                got++;
                e = q0.size() > 0 ? q0.pop_front() : '1;
                tests++; if ({cout, sum} !== e) begin fails++; $display("FAIL bp_result: got %b/%h want %b/%h", cout, sum, e[256], e[255:0]); end
            end
            if (in_valid && in_ready) begin
                q0.push_back(model(a, b, cin, c_en, 256, 64));
                sent++;
                need = 1'b1;
            end
            stall_prev = out_valid && !out_ready;
            sum_prev = sum;
            cout_prev = cout;
            tick();
            cyc++;
        end
        tests++; if (got !== 10 || q0.size() !== 0) begin fails++; $display("FAIL bp_count: got %0d left %0d want 10/0", got, q0.size()); end
        drain();
    endtask

    task automatic test_reset_midflight();
        int stale, lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = rand256() | 256'd1; b = rand256(); cin = 1'b0; c_en = 1'b1; in_valid = 1'b1;
            rst = i == 2;
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        tests++; if (sum !== 256'd0) begin fails++; $display("FAIL midrst_sum: got %h want 0", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL midrst_cout: got %b want 0", cout); end
        stale = 0;
        repeat (8) begin
            tick();
            if (out_valid !== 1'b0 || sum !== 256'd0) stale++;
        end
        tests++; if (stale !== 0) begin fails++; $display("FAIL midrst_stale: got %0d stale cycles want 0", stale); end
        a = {64'd5, 64'd7, 64'd9, 64'd11}; b = {64'd1, 64'd2, 64'd3, 64'd4}; cin = 1'b1; c_en = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        tests++; if (lat !== 4) begin fails++; $display("FAIL midrst_latency: got %0d want 4", lat); end
        tests++; if (sum !== {64'd6, 64'd9, 64'd12, 64'd16} || cout !== 1'b0) begin
            fails++; $display("FAIL midrst_result: got %b/%h want 0/%h", cout, sum, {64'd6, 64'd9, 64'd12, 64'd16});
        end
        drain();
    endtask

    task automatic test_sweep();
        int sent64, sent32, got64, got32, cyc;
        logic [256:0] e;
        q64.delete(); q32.delete();
        sent64 = 0; sent32 = 0; got64 = 0; got32 = 0; cyc = 0;
        while ((got64 < 1000 || got32 < 1000) && cyc < 4000) begin
            s64_in_valid = sent64 < 1000 && $urandom_range(0, 3) != 0;
            s64_a = {$urandom, $urandom}; s64_b = {$urandom, $urandom};
            s64_cin = $urandom_range(0, 1) == 1; s64_c_en = $urandom_range(0, 1) == 1;
            s32_in_valid = sent32 < 1000 && $urandom_range(0, 3) != 0;
            s32_a = $urandom; s32_b = $urandom;
            s32_cin = $urandom_range(0, 1) == 1; s32_c_en = $urandom_range(0, 1) == 1;
            #1;
            if (s64_out_valid) begin
                got64++;
                e = q64.size() > 0 ? q64.pop_front() : '1;
                tests++; if ({s64_cout, s64_sum} !== {e[256], e[63:0]}) begin
                    fails++; $display("FAIL sweep64_result: got %b/%h want %b/%h", s64_cout, s64_sum, e[256], e[63:0]);
                end
            end
            if (s32_out_valid) begin
                got32++;
                e = q32.size() > 0 ? q32.pop_front() : '1;
                tests++; if ({s32_cout, s32_sum} !== {e[256], e[31:0]}) begin
                    fails++; $display("FAIL sweep32_result: got %b/%h want %b/%h", s32_cout, s32_sum, e[256], e[31:0]);
                end
            end
            if (s64_in_valid && s64_in_ready) begin
                q64.push_back(model({192'd0, s64_a}, {192'd0, s64_b}, s64_cin, s64_c_en, 64, 64));
                sent64++;
            end
            if (s32_in_valid && s32_in_ready) begin
                q32.push_back(model({224'd0, s32_a}, {224'd0, s32_b}, s32_cin, s32_c_en, 32, 8));
                sent32++;
            end
            tick();
            cyc++;
        end
        tests++; if (got64 !== 1000 || q64.size() !== 0) begin fails++; $display("FAIL sweep64_count: got %0d want 1000", got64); end
        tests++; if (got32 !== 1000 || q32.size() !== 0) begin fails++; $display("FAIL sweep32_count: got %0d want 1000", got32); end
        s64_in_valid = 1'b0;
        s32_in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; c_en = 1'b0;
        s64_in_valid = 1'b0; s64_a = '0; s64_b = '0; s64_cin = 1'b0; s64_c_en = 1'b0;
        s32_in_valid = 1'b0; s32_a = '0; s32_b = '0; s32_cin = 1'b0; s32_c_en = 1'b0;
        test_reset();
        test_full_ripple();
        test_lane();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
